// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divider: FSM states,
// default operand widths and the most-negative-value helper.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } div_state_e;

    localparam int DEF_DW = 8;
    localparam int DEF_VW = 4;

    // Bit pattern of -2^(width-1); callers cast down to their own width.
    function automatic logic [63:0] most_negative(input int width);
        return 64'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/sgn_mag_conv.sv
// Two's-complement <-> sign/magnitude converter. Magnitudes are unsigned W-bit,
// so the most-negative input maps to 2^(W-1) without truncation.
module sgn_mag_conv #(
    parameter int W = 8
) (
    input  logic [W-1:0] signed_in,
    output logic         sign_out,
    output logic [W-1:0] mag_out,
    input  logic         sign_in,
    input  logic [W-1:0] mag_in,
    output logic [W-1:0] signed_out
);

    assign sign_out   = signed_in[W-1];
    assign mag_out    = signed_in[W-1] ? -signed_in : signed_in;
    assign signed_out = sign_in ? -mag_in : mag_in;

endmodule

// File: rtl/seq_signed_divider.sv
// Sequential restoring signed divider with truncating (Verilog / and %) semantics,
// one quotient bit per cycle, valid/ready handshakes on both sides.
module seq_signed_divider
    import div_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int VW = DEF_VW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero,
    output logic          overflow
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(DW - 1);
    localparam logic [DW-1:0] MOST_NEG = DW'(most_negative(DW));

    div_state_e state, state_nxt;

    logic          dvd_sign, dvs_sign;
    logic [DW-1:0] dvd_mag;
    logic [VW-1:0] dvs_mag;
    logic [DW-1:0] work;
    logic [VW-1:0] dvs_mag_reg;
    logic [VW:0]   prem;
    logic [CW-1:0] cnt;
    logic          sq, sr;
    logic [DW-1:0] q_signed;
    logic [VW-1:0] r_signed;
    logic [VW+1:0] shifted, trial;
    logic          trial_ok;

    // The dividend converter also signs the quotient; the divisor one signs the remainder.
    sgn_mag_conv #(.W(DW)) u_dvd_conv (
        .signed_in  (dividend),
        .sign_out   (dvd_sign),
        .mag_out    (dvd_mag),
        .sign_in    (sq),
        .mag_in     (work),
        .signed_out (q_signed)
    );

    sgn_mag_conv #(.W(VW)) u_dvs_conv (
        .signed_in  (divisor),
        .sign_out   (dvs_sign),
        .mag_out    (dvs_mag),
        .sign_in    (sr),
        .mag_in     (prem[VW-1:0]),
        .signed_out (r_signed)
    );

    // Work register shifts dividend bits out of the top and quotient bits in at the bottom.
    assign shifted  = {prem, work[DW-1]};
    assign trial    = shifted - {2'b00, dvs_mag_reg};
    assign trial_ok = (shifted >= {2'b00, dvs_mag_reg});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = (divisor == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt == '0) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work        <= '0;
            dvs_mag_reg <= '0;
            prem        <= '0;
            cnt         <= '0;
            sq          <= 1'b0;
            sr          <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work        <= dvd_mag;
                        dvs_mag_reg <= dvs_mag;
                        sq          <= dvd_sign ^ dvs_sign;
                        sr          <= dvd_sign;
                        prem        <= '0;
                        cnt         <= CNT_INIT;
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= '0;
                            div_by_zero <= 1'b1;
                            overflow    <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    prem <= trial_ok ? (VW+1)'(trial) : (VW+1)'(shifted);
                    work <= {work[DW-2:0], trial_ok};
                    cnt  <= cnt - CW'(1);
                end
                FIX: begin
                    // A positive quotient magnitude of 2^(DW-1) only arises from MIN / -1.
                    quotient    <= q_signed;
                    remainder   <= r_signed;
                    overflow    <= !sq && (work == MOST_NEG);
                    div_by_zero <= 1'b0;
                end
                DONE: begin
                    if (out_ready) begin
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
